// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared definitions for the FPU decode stage: instruction
//               field offsets, opcode encoding, sizing constants, the issue
//               payload struct and small helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int FP_NUM_REGS = 32;
    localparam int FP_XLEN     = 32;
    localparam int FP_IMM_W    = 13;
    localparam int FP_REG_AW   = 5;

    // Instruction layout: [31:28] op, [27:23] rd, [22:18] rs1, [17:13] rs2, [12:0] imm
    localparam int F_OP_LSB  = 28;
    localparam int F_OP_W    = 4;
    localparam int F_RD_LSB  = 23;
    localparam int F_RS1_LSB = 18;
    localparam int F_RS2_LSB = 13;
    localparam int F_IMM_LSB = 0;

    typedef enum logic [F_OP_W-1:0] {
        OP_FADD  = 4'd0,
        OP_FSUB  = 4'd1,
        OP_FADDI = 4'd2
    } fpu_op_e;

    typedef struct packed {
        logic [FP_XLEN-1:0]   a;
        logic [FP_XLEN-1:0]   b;
        logic [FP_REG_AW-1:0] rd;
    } fp_issue_t;

    // Flip only the IEEE-754 sign bit, turning a + b into a + (-b).
    function automatic logic [FP_XLEN-1:0] fp_neg(input logic [FP_XLEN-1:0] v);
        return {~v[FP_XLEN-1], v[FP_XLEN-2:0]};
    endfunction

    // The immediate occupies the top bits: sign, exponent, top mantissa bits.
    function automatic logic [FP_XLEN-1:0] fp_expand_imm(input logic [FP_IMM_W-1:0] imm);
        return {imm, {(FP_XLEN-FP_IMM_W){1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_decode_stage_if
// Description : Bundle of the decode stage's instruction input handshake,
//               issue output handshake, write-back port and error pulse.
//               master : upstream/downstream environment driving the stage
//               slave  : the decode stage itself
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [31:0]     in_instr;
    logic            in_ready;
    logic            issue_valid;
    logic            issue_ready;
    logic [XLEN-1:0] issue_a;
    logic [XLEN-1:0] issue_b;
    logic [4:0]      issue_rd;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            err_illegal;

    modport master (
        output in_valid, in_instr, issue_ready, wb_en, wb_rd, wb_data,
        input  in_ready, issue_valid, issue_a, issue_b, issue_rd, err_illegal
    );

    modport slave (
        input  in_valid, in_instr, issue_ready, wb_en, wb_rd, wb_data,
        output in_ready, issue_valid, issue_a, issue_b, issue_rd, err_illegal
    );
endinterface
`default_nettype wire

// File: rtl/fp_regfile.sv
`default_nettype none
// ============================================================================
// Module      : fp_regfile
// Description : FP register file, 2 read / 1 write ports, flop array reset
//               to zero. Register 0 always reads as +0.0 and ignores writes.
//               A read of the register being written this cycle returns the
//               write data (write-to-read bypass).
// Ports       : clk, rst_n            clock, async active-low reset
//               i_we/i_waddr/i_wdata  write port
//               i_raddr_a/o_rdata_a   read port A
//               i_raddr_b/o_rdata_b   read port B
// Revision    : 1.0 - initial release
// ============================================================================
module fp_regfile #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int AW       = 5
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            i_we,
    input  wire logic [AW-1:0]   i_waddr,
    input  wire logic [XLEN-1:0] i_wdata,
    input  wire logic [AW-1:0]   i_raddr_a,
    input  wire logic [AW-1:0]   i_raddr_b,
    output logic      [XLEN-1:0] o_rdata_a,
    output logic      [XLEN-1:0] o_rdata_b
);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            w_wr_live;

    assign w_wr_live = i_we && (i_waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        o_rdata_b = r_regs[i_raddr_b];
        if (w_wr_live && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
        if (w_wr_live && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
        if (i_raddr_a == '0) o_rdata_a = '0;
        if (i_raddr_b == '0) o_rdata_b = '0;
    end

endmodule
`default_nettype wire

// File: rtl/fpu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : fpu_decode_stage
// Description : Decode stage of the 3-stage FPU pipeline. Decodes FADD,
//               FSUB and FADDI, reads operands (with write-back bypass),
//               tracks RAW/WAW hazards with a busy-bit scoreboard and issues
//               operands to Execute through a valid/ready register.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    fpu_decode_stage_if.slave: instruction in, issue out,
//                      write-back port, one-cycle illegal-opcode pulse
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_decode_stage
    import fpu_pkg::*;
#(
    parameter int NUM_REGS = FP_NUM_REGS,
    parameter int XLEN     = FP_XLEN,
    parameter int IMM_W    = FP_IMM_W
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fpu_decode_stage_if.slave bus
);

    // ---------------- field extraction ----------------
    logic [F_OP_W-1:0]    w_op;
    logic [FP_REG_AW-1:0] w_rd;
    logic [FP_REG_AW-1:0] w_rs1;
    logic [FP_REG_AW-1:0] w_rs2;
    logic [IMM_W-1:0]     w_imm;

    assign w_op  = bus.in_instr[F_OP_LSB  +: F_OP_W];
    assign w_rd  = bus.in_instr[F_RD_LSB  +: FP_REG_AW];
    assign w_rs1 = bus.in_instr[F_RS1_LSB +: FP_REG_AW];
    assign w_rs2 = bus.in_instr[F_RS2_LSB +: FP_REG_AW];
    assign w_imm = bus.in_instr[F_IMM_LSB +: IMM_W];

    // ---------------- operand read ----------------
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    fp_regfile #(
        .NUM_REGS (NUM_REGS),
        .XLEN     (XLEN),
        .AW       (FP_REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (bus.wb_en),
        .i_waddr   (bus.wb_rd),
        .i_wdata   (bus.wb_data),
        .i_raddr_a (w_rs1),
        .i_raddr_b (w_rs2),
        .o_rdata_a (w_rs1_val),
        .o_rdata_b (w_rs2_val)
    );

    // ---------------- decode ----------------
    logic            w_legal;
    logic            w_uses_rs2;
    logic [XLEN-1:0] w_op_b;

    always_comb begin
        w_legal    = 1'b0;
        w_uses_rs2 = 1'b0;
        w_op_b     = w_rs2_val;
        case (w_op)
            OP_FADD: begin
                w_legal    = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OP_FSUB: begin
                w_legal    = 1'b1;
                w_uses_rs2 = 1'b1;
                w_op_b     = fp_neg(w_rs2_val);
            end
            OP_FADDI: begin
                w_legal    = 1'b1;
                w_op_b     = fp_expand_imm(w_imm);
            end
            default: begin
                w_legal    = 1'b0;
            end
        endcase
    end

    // ---------------- scoreboard ----------------
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_wb_clr;
    logic [NUM_REGS-1:0] w_busy_eff;
    logic [NUM_REGS-1:0] w_busy_set;
    logic                w_hazard;
    logic                w_in_ready;
    logic                w_accept;

    logic                r_issue_valid;
    fp_issue_t           r_issue;
    logic                r_err;

    assign w_wb_clr = (bus.wb_en && (bus.wb_rd != '0)) ? (NUM_REGS'(1) << bus.wb_rd) : '0;

    // A write-back landing this cycle already resolves its hazard, so the
    // cleared view of the busy bits is what gates acceptance.
    assign w_busy_eff = r_busy & ~w_wb_clr;

    // Illegal opcodes never read rs2, so only rs1/rd can hold them off.
    assign w_hazard   = w_busy_eff[w_rs1]
                      | (w_uses_rs2 & w_busy_eff[w_rs2])
                      | w_busy_eff[w_rd];

    assign w_in_ready = ~w_hazard & (~r_issue_valid | bus.issue_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    assign w_busy_set = (w_accept && w_legal && (w_rd != '0)) ? (NUM_REGS'(1) << w_rd) : '0;

    // ---------------- issue register / error pulse ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_issue       <= '0;
            r_err         <= 1'b0;
            r_busy        <= '0;
        end else begin
            r_err <= w_accept & ~w_legal;
            if (w_accept && w_legal) begin
                r_issue_valid <= 1'b1;
                r_issue.a     <= w_rs1_val;
                r_issue.b     <= w_op_b;
                r_issue.rd    <= w_rd;
            end else if (bus.issue_ready) begin
                r_issue_valid <= 1'b0;
            end
            // Set is applied after clear: the issuing instruction is newer
            // than the one writing back to the same register.
            r_busy <= (r_busy & ~w_wb_clr) | w_busy_set;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_a     = r_issue.a;
    assign bus.issue_b     = r_issue.b;
    assign bus.issue_rd    = r_issue.rd;
    assign bus.err_illegal = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fpu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_decode_stage
// Description : Self-checking bench for fpu_decode_stage. Directed scenarios
//               followed by randomized traffic, all compared against an
//               instruction-level model of the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    fpu_decode_stage_if #(.XLEN(32)) bus ();

    fpu_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model state ----------------
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_iv;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_iv = 0; m_a = 0; m_b = 0; m_rd = 0; m_err = 0;
    endtask

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                       input int rs2, input int imm);
        return {op[3:0], rd[4:0], rs1[4:0], rs2[4:0], imm[12:0]};
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input bit ir,
                         input bit we, input int wr, input logic [31:0] wd);
        bus.in_valid    = v;
        bus.in_instr    = ins;
        bus.issue_ready = ir;
        bus.wb_en       = we;
        bus.wb_rd       = wr[4:0];
        bus.wb_data     = wd;
    endtask

    // Architectural view: register value as seen this cycle, with write-back forwarding.
    function automatic logic [31:0] src(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
        return m_regs[r];
    endfunction

    function automatic bit busy_now(input logic [4:0] r);
        if (bus.wb_en && bus.wb_rd != 0 && bus.wb_rd == r) return 1'b0;
        return m_busy[r];
    endfunction

    // One clock: check the combinational ready, advance the model, check issue outputs.
    task automatic step();
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [12:0] imm;
        logic [31:0] s1, s2;
        bit legal, uses2, haz, exp_rdy, acc;
        #1;
        op  = bus.in_instr[31:28];
        rd  = bus.in_instr[27:23];
        rs1 = bus.in_instr[22:18];
        rs2 = bus.in_instr[17:13];
        imm = bus.in_instr[12:0];
        legal = (op <= 4'd2);
        uses2 = (op <= 4'd1);
        haz = busy_now(rs1) || (uses2 && busy_now(rs2)) || busy_now(rd);
        exp_rdy = !haz && (!m_iv || bus.issue_ready);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = bus.in_valid && exp_rdy;
        s1 = src(rs1);
        s2 = src(rs2);
        if (acc && legal) begin
            m_iv = 1;
            m_a  = s1;
            m_rd = rd;
            case (op)
                4'd0:    m_b = s2;
                4'd1:    m_b = s2 ^ 32'h8000_0000;
                default: m_b = 32'(imm) << 19;
            endcase
        end else if (bus.issue_ready) begin
            m_iv = 0;
        end
        m_err = acc && !legal;
        if (bus.wb_en && bus.wb_rd != 0) begin
            m_regs[bus.wb_rd] = bus.wb_data;
            m_busy[bus.wb_rd] = 1'b0;
        end
        if (acc && legal && rd != 0) m_busy[rd] = 1'b1;
        @(posedge clk);
        #1;
        chk("issue_valid", 32'(bus.issue_valid), 32'(m_iv));
        chk("err_illegal", 32'(bus.err_illegal), 32'(m_err));
        if (m_iv) begin
            chk("issue_a", bus.issue_a, m_a);
            chk("issue_b", bus.issue_b, m_b);
            chk("issue_rd", 32'(bus.issue_rd), 32'(m_rd));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 32'h0, 1, 0, 0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'h0);
        chk("rst_err", 32'(bus.err_illegal), 32'h0);
        chk("rst_issue_a", bus.issue_a, 32'h0);
        chk("rst_issue_b", bus.issue_b, 32'h0);
        chk("rst_issue_rd", 32'(bus.issue_rd), 32'h0);
        rst_n = 1'b1;

        // Mid-stream reset: an issue is held and another instruction is pending.
        drive(1, mk(0, 13, 0, 0, 0), 0, 0, 0, 32'h0);
        step();
        drive(1, mk(0, 14, 13, 0, 0), 0, 0, 0, 32'h0);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_issue_valid", 32'(bus.issue_valid), 32'h0);
        chk("midrst_err", 32'(bus.err_illegal), 32'h0);
        model_reset();
        drive(0, 32'h0, 1, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FADD f1,f0,f0 after reset
        drive(1, mk(0, 1, 0, 0, 0), 1, 0, 0, 32'h0);
        step();
        chk("t1_a", bus.issue_a, 32'h0);
        chk("t1_b", bus.issue_b, 32'h0);

        // Bypass: write f2 while accepting FADD f3,f2,f0
        drive(1, mk(0, 3, 2, 0, 0), 1, 1, 2, 32'h3F80_0000);
        step();
        chk("bypass_a", bus.issue_a, 32'h3F80_0000);

        // RAW stall: retire f1, issue FADD f4,f1,f1, then FADD f5,f4,f1 waits on f4
        drive(0, 32'h0, 1, 1, 1, 32'h4040_0000);
        step();
        drive(1, mk(0, 4, 1, 1, 0), 1, 0, 0, 32'h0);
        step();
        drive(1, mk(0, 5, 4, 1, 0), 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("raw_stall_ready", 32'(bus.in_ready), 32'h0);
            step();
        end
        drive(1, mk(0, 5, 4, 1, 0), 1, 1, 4, 32'h4100_0000);
        step();
        chk("raw_bypass_a", bus.issue_a, 32'h4100_0000);
        chk("raw_bypass_rd", 32'(bus.issue_rd), 32'd5);

        // FSUB sign flip and FADDI immediate
        drive(0, 32'h0, 1, 1, 6, 32'h4000_0000);
        step();
        drive(1, mk(1, 7, 0, 6, 0), 1, 0, 0, 32'h0);
        step();
        chk("fsub_b", bus.issue_b, 32'hC000_0000);
        drive(1, mk(2, 8, 0, 0, 13'h0FE0), 1, 0, 0, 32'h0);
        step();
        chk("faddi_b", bus.issue_b, 32'h7F00_0000);

        // Backpressure
        drive(1, mk(0, 9, 0, 0, 0), 1, 0, 0, 32'h0);
        step();
        drive(1, mk(0, 10, 0, 0, 0), 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_rd_stable", 32'(bus.issue_rd), 32'd9);
            chk("bp_a_stable", bus.issue_a, 32'h0);
        end
        drive(1, mk(0, 10, 0, 0, 0), 1, 0, 0, 32'h0);
        step();
        chk("bp_release_rd", 32'(bus.issue_rd), 32'd10);

        // Illegal opcode
        drive(1, mk(15, 11, 0, 0, 0), 1, 0, 0, 32'h0);
        step();
        chk("illegal_err", 32'(bus.err_illegal), 32'h1);
        drive(1, mk(0, 12, 11, 0, 0), 1, 0, 0, 32'h0);
        #1;
        chk("illegal_no_busy", 32'(bus.in_ready), 32'h1);
        step();
        chk("illegal_err_once", 32'(bus.err_illegal), 32'h0);

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 500; n++) begin
            int op, k, wr;
            bit we;
            k = $urandom_range(0, 9);
            if (k <= 2)      op = 0;
            else if (k <= 5) op = 1;
            else if (k <= 8) op = 2;
            else             op = $urandom_range(3, 15);
            we = ($urandom_range(0, 2) != 0);
            wr = $urandom_range(0, 7);
            k  = $urandom_range(0, 7);
            for (int j = 0; j < 8; j++) begin
                if (m_busy[(k + j) % 8]) begin
                    wr = (k + j) % 8;
                    break;
                end
            end
            drive($urandom_range(0, 4) != 0,
                  mk(op, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 8191)),
                  $urandom_range(0, 3) != 0, we, wr, $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
